// File: rtl/ex_branch_if.sv
// Issue/redirect bundle between the branch reservation station, the branch
// execution unit and fetch.
`ifndef dataWidth
`define dataWidth 32
`endif
`ifndef addrWidth
`define addrWidth 32
`endif
`ifndef newopWidth
`define newopWidth 6
`endif
`ifndef BEQ
`define BEQ  6'h18
`define BNE  6'h19
`define BLT  6'h1C
`define BGE  6'h1D
`define BLTU 6'h1E
`define BGEU 6'h1F
`endif

// Handshake: fetch takes the head result at a rising edge where
// redirect_valid && redirect_ready are both high; while redirect_ready is low
// redirect_valid and the head entry stay stable. The issue side has no back
// pressure: ex_branch_en presents one branch per cycle.
interface ex_branch_if;
    logic                   ex_branch_en;
    logic [`dataWidth-1:0]  exsrc1_in;
    logic [`dataWidth-1:0]  exsrc2_in;
    logic [`addrWidth-1:0]  expc_in;
    logic [`newopWidth-1:0] exaluop_in;
    logic [`dataWidth-1:0]  exoffset_in;
    logic                   redirect_ready;
    logic                   redirect_valid;
    logic [`addrWidth-1:0]  redirect_pc;
    logic                   redirect_taken;

    modport master (
        output ex_branch_en, exsrc1_in, exsrc2_in, expc_in, exaluop_in,
               exoffset_in, redirect_ready,
        input  redirect_valid, redirect_pc, redirect_taken
    );

    modport slave (
        input  ex_branch_en, exsrc1_in, exsrc2_in, expc_in, exaluop_in,
               exoffset_in, redirect_ready,
        output redirect_valid, redirect_pc, redirect_taken
    );
endinterface

// File: rtl/ex_branch.sv
// Branch execution unit: resolves branch condition and next PC, and queues
// {target, taken} results in a small circular FIFO feeding fetch redirects.
`ifndef dataWidth
`define dataWidth 32
`endif
`ifndef addrWidth
`define addrWidth 32
`endif
`ifndef newopWidth
`define newopWidth 6
`endif
`ifndef BEQ
`define BEQ  6'h18
`define BNE  6'h19
`define BLT  6'h1C
`define BGE  6'h1D
`define BLTU 6'h1E
`define BGEU 6'h1F
`endif

module ex_branch #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    ex_branch_if.slave  br,
    output logic        resolve_en,
    output logic        queue_full,
    output logic        overflow_err,
    output logic [31:0] branch_cnt,
    output logic [31:0] taken_cnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic                  taken_c;
    logic [`addrWidth-1:0] target_c;
    logic                  pop_c;
    logic                  push_c;
    logic                  drop_c;
    logic                  full_c;
    logic                  empty_c;

    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  resolve_q;
    logic                  overflow_q;
    logic [31:0]           branch_cnt_q;
    logic [31:0]           taken_cnt_q;

    logic [`addrWidth-1:0] tgt_mem [DEPTH];
    logic                  tk_mem  [DEPTH];

    // Branch condition from the resolved operands; unknown opcodes fall through as not-taken.
    always_comb begin
        taken_c = 1'b0;
        case (br.exaluop_in)
            `BEQ:    taken_c = (br.exsrc1_in == br.exsrc2_in);
            `BNE:    taken_c = (br.exsrc1_in != br.exsrc2_in);
            `BLT:    taken_c = ($signed(br.exsrc1_in) <  $signed(br.exsrc2_in));
            `BGE:    taken_c = ($signed(br.exsrc1_in) >= $signed(br.exsrc2_in));
            `BLTU:   taken_c = (br.exsrc1_in <  br.exsrc2_in);
            `BGEU:   taken_c = (br.exsrc1_in >= br.exsrc2_in);
            default: taken_c = 1'b0;
        endcase
    end

    // Next PC, truncated to the address width so wrap-around is silent.
    always_comb begin
        target_c = br.expc_in + `addrWidth'(4);
        if (taken_c) begin
            target_c = br.expc_in + br.exoffset_in[`addrWidth-1:0];
        end
    end

    // Queue control: a pop frees the slot a same-cycle push needs, so a full
    // queue still accepts a branch when fetch is taking the head.
    always_comb begin
        empty_c = (count_q == '0);
        full_c  = (count_q == CW'(DEPTH));
        pop_c   = !empty_c && br.redirect_ready;
        push_c  = br.ex_branch_en && (!full_c || pop_c);
        drop_c  = br.ex_branch_en && full_c && !pop_c;
        wptr_d  = push_c ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop_c  ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q;
        if (push_c && !pop_c) begin
            count_d = count_q + 1'b1;
        end else if (pop_c && !push_c) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers, occupancy, status flags and statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            resolve_q    <= 1'b0;
            overflow_q   <= 1'b0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            resolve_q <= push_c;
            if (drop_c) begin
                overflow_q <= 1'b1;
            end
            if (push_c) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
                if (taken_c) begin
                    taken_cnt_q <= taken_cnt_q + 32'd1;
                end
            end
        end
    end

    // Entry storage; contents are only observable while counted as occupied,
    // so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            tgt_mem[wptr_q] <= target_c;
            tk_mem[wptr_q]  <= taken_c;
        end
    end

    // Head entry presented to fetch, forced to zero when the queue is empty.
    always_comb begin
        br.redirect_valid = !empty_c;
        br.redirect_pc    = '0;
        br.redirect_taken = 1'b0;
        if (!empty_c) begin
            br.redirect_pc    = tgt_mem[rptr_q];
            br.redirect_taken = tk_mem[rptr_q];
        end
    end

    assign resolve_en   = resolve_q;
    assign queue_full   = full_c;
    assign overflow_err = overflow_q;
    assign branch_cnt   = branch_cnt_q;
    assign taken_cnt    = taken_cnt_q;
endmodule

// File: tb/tb_ex_branch.sv
// Bench for ex_branch: a negedge scoreboard predicts every redirect and
// status output; scenario tasks add targeted checks.
`ifndef dataWidth
`define dataWidth 32
`endif
`ifndef addrWidth
`define addrWidth 32
`endif
`ifndef newopWidth
`define newopWidth 6
`endif
`ifndef BEQ
`define BEQ  6'h18
`define BNE  6'h19
`define BLT  6'h1C
`define BGE  6'h1D
`define BLTU 6'h1E
`define BGEU 6'h1F
`endif

module tb_ex_branch;
  localparam int DEPTH = 2;
  localparam logic [5:0] OP_BAD = 6'h3F;

  logic        clk;
  logic        rst;
  logic        resolve_en;
  logic        queue_full;
  logic        overflow_err;
  logic [31:0] branch_cnt;
  logic [31:0] taken_cnt;

  ex_branch_if bif ();

  ex_branch #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .br           (bif),
    .resolve_en   (resolve_en),
    .queue_full   (queue_full),
    .overflow_err (overflow_err),
    .branch_cnt   (branch_cnt),
    .taken_cnt    (taken_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // scoreboard state: {target, taken} per queued entry
  logic [32:0] exp_q[$];
  logic [31:0] m_branch;
  logic [31:0] m_taken;
  logic        m_ovf;
  logic        m_res;

  function automatic logic exp_cond(input logic [5:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    case (op)
      `BEQ:    return a == b;
      `BNE:    return a != b;
      `BLT:    return $signed(a) < $signed(b);
      `BGE:    return $signed(a) >= $signed(b);
      `BLTU:   return a < b;
      `BGEU:   return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // scoreboard: compare outputs against the model, then advance it with the
  // inputs that the next rising edge will see
  always @(negedge clk) begin
    logic        pop;
    logic        acc;
    logic        tk;
    logic [31:0] tgt;
    logic [32:0] head;
    if (rst) begin
      exp_q.delete();
      m_branch = 0;
      m_taken  = 0;
      m_ovf    = 0;
      m_res    = 0;
    end else begin
      vectors++;
      if (bif.redirect_valid !== (exp_q.size() != 0)) begin
        miscompares++;
        $display("FAIL sb_valid: got %b want %b", bif.redirect_valid, exp_q.size() != 0);
      end
      head = (exp_q.size() != 0) ? exp_q[0] : 33'd0;
      vectors++;
      if ({bif.redirect_pc, bif.redirect_taken} !== head) begin
        miscompares++;
        $display("FAIL sb_head: got pc=%h tk=%b want pc=%h tk=%b",
                 bif.redirect_pc, bif.redirect_taken, head[32:1], head[0]);
      end
      vectors++;
      if ({queue_full, overflow_err, resolve_en} !==
          {exp_q.size() == DEPTH, m_ovf, m_res}) begin
        miscompares++;
        $display("FAIL sb_flags: got full=%b ovf=%b res=%b want full=%b ovf=%b res=%b",
                 queue_full, overflow_err, resolve_en, exp_q.size() == DEPTH, m_ovf, m_res);
      end
      vectors++;
      if (branch_cnt !== m_branch || taken_cnt !== m_taken) begin
        miscompares++;
        $display("FAIL sb_counts: got br=%0d tk=%0d want br=%0d tk=%0d",
                 branch_cnt, taken_cnt, m_branch, m_taken);
      end
      pop = (exp_q.size() != 0) && bif.redirect_ready;
      acc = bif.ex_branch_en && ((exp_q.size() < DEPTH) || pop);
      tk  = exp_cond(bif.exaluop_in, bif.exsrc1_in, bif.exsrc2_in);
      tgt = tk ? bif.expc_in + bif.exoffset_in : bif.expc_in + 32'd4;
      if (pop) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back({tgt, tk});
        m_branch = m_branch + 1;
        if (tk) m_taken = m_taken + 1;
      end
      if (bif.ex_branch_en && !acc) m_ovf = 1'b1;
      m_res = acc;
    end
  end

  // driver tasks: called at posedge+1, return at posedge+1
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] off);
    bif.ex_branch_en = 1'b1;
    bif.exaluop_in   = op;
    bif.exsrc1_in    = a;
    bif.exsrc2_in    = b;
    bif.expc_in      = pc;
    bif.exoffset_in  = off;
    @(posedge clk);
    #1;
    bif.ex_branch_en = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d entries left, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    vectors++;
    if ({bif.redirect_valid, bif.redirect_pc, bif.redirect_taken, resolve_en, queue_full,
         overflow_err, branch_cnt, taken_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b pc=%h tk=%b res=%b full=%b ovf=%b br=%0d tkc=%0d",
               bif.redirect_valid, bif.redirect_pc, bif.redirect_taken, resolve_en,
               queue_full, overflow_err, branch_cnt, taken_cnt);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_beq();
    bif.redirect_ready = 1'b1;
    issue(`BEQ, 32'd5, 32'd5, 32'h100, 32'h20);
    @(negedge clk);
    vectors++;
    if ({bif.redirect_valid, bif.redirect_pc, bif.redirect_taken, resolve_en, taken_cnt} !==
        {1'b1, 32'h120, 1'b1, 1'b1, 32'd1}) begin
      miscompares++;
      $display("FAIL beq: got valid=%b pc=%h tk=%b res=%b tkc=%0d want 1 120 1 1 1",
               bif.redirect_valid, bif.redirect_pc, bif.redirect_taken, resolve_en, taken_cnt);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if (resolve_en !== 1'b0 || bif.redirect_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL beq_pulse: got res=%b valid=%b want 0 0", resolve_en, bif.redirect_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_signed();
    bif.redirect_ready = 1'b1;
    issue(`BLT, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40);
    @(negedge clk);
    vectors++;
    if ({bif.redirect_pc, bif.redirect_taken} !== {32'h240, 1'b1}) begin
      miscompares++;
      $display("FAIL blt_signed: got pc=%h tk=%b want 240 1", bif.redirect_pc, bif.redirect_taken);
    end
    @(posedge clk);
    #1;
    issue(`BLTU, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40);
    @(negedge clk);
    vectors++;
    if ({bif.redirect_pc, bif.redirect_taken} !== {32'h204, 1'b0}) begin
      miscompares++;
      $display("FAIL bltu_unsigned: got pc=%h tk=%b want 204 0", bif.redirect_pc, bif.redirect_taken);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_overflow();
    test_reset();
    bif.redirect_ready = 1'b0;
    issue(`BNE, 32'd1, 32'd2, 32'h1000, 32'h10);
    issue(`BGE, 32'd1, 32'd2, 32'h2000, 32'h10);
    issue(`BGEU, 32'd3, 32'd2, 32'h3000, 32'h10);
    @(negedge clk);
    vectors++;
    if ({queue_full, overflow_err, branch_cnt} !== {1'b1, 1'b1, 32'd2}) begin
      miscompares++;
      $display("FAIL overflow: got full=%b ovf=%b br=%0d want 1 1 2",
               queue_full, overflow_err, branch_cnt);
    end
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if ({bif.redirect_valid, bif.redirect_pc} !== {1'b1, 32'h1010}) begin
        miscompares++;
        $display("FAIL hold_head: got valid=%b pc=%h want 1 1010",
                 bif.redirect_valid, bif.redirect_pc);
      end
    end
    @(posedge clk);
    #1;
    bif.redirect_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (bif.redirect_pc !== 32'h1010) begin
      miscompares++;
      $display("FAIL drain0: got %h want 1010", bif.redirect_pc);
    end
    @(negedge clk);
    vectors++;
    if (bif.redirect_pc !== 32'h2004 || overflow_err !== 1'b1) begin
      miscompares++;
      $display("FAIL drain1: got pc=%h ovf=%b want 2004 1", bif.redirect_pc, overflow_err);
    end
    @(posedge clk);
    #1;
    wait_drain();
  endtask

  task automatic test_full_pushpop();
    test_reset();
    bif.redirect_ready = 1'b0;
    issue(`BEQ, 32'd7, 32'd7, 32'h4000, 32'h100);
    issue(`BEQ, 32'd7, 32'd8, 32'h5000, 32'h100);
    bif.redirect_ready = 1'b1;
    issue(`BNE, 32'd7, 32'd8, 32'h6000, 32'h80);
    @(negedge clk);
    vectors++;
    if ({queue_full, overflow_err, bif.redirect_pc, branch_cnt} !==
        {1'b1, 1'b0, 32'h5004, 32'd3}) begin
      miscompares++;
      $display("FAIL push_pop_full: got full=%b ovf=%b pc=%h br=%0d want 1 0 5004 3",
               queue_full, overflow_err, bif.redirect_pc, branch_cnt);
    end
    @(negedge clk);
    vectors++;
    if (bif.redirect_pc !== 32'h6080) begin
      miscompares++;
      $display("FAIL push_pop_order: got %h want 6080", bif.redirect_pc);
    end
    @(posedge clk);
    #1;
    wait_drain();
  endtask

  task automatic test_wrap_and_bad_op();
    bif.redirect_ready = 1'b1;
    issue(`BEQ, 32'd9, 32'd9, 32'hFFFF_FFF0, 32'h20);
    @(negedge clk);
    vectors++;
    if ({bif.redirect_pc, bif.redirect_taken} !== {32'h0000_0010, 1'b1}) begin
      miscompares++;
      $display("FAIL pc_wrap: got pc=%h tk=%b want 00000010 1", bif.redirect_pc, bif.redirect_taken);
    end
    @(posedge clk);
    #1;
    issue(OP_BAD, 32'd9, 32'd9, 32'h700, 32'h20);
    @(negedge clk);
    vectors++;
    if ({bif.redirect_pc, bif.redirect_taken, resolve_en} !== {32'h704, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL bad_op: got pc=%h tk=%b res=%b want 704 0 1",
               bif.redirect_pc, bif.redirect_taken, resolve_en);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [5:0] ops[7];
    ops = '{`BEQ, `BNE, `BLT, `BGE, `BLTU, `BGEU, OP_BAD};
    test_reset();
    for (int i = 0; i < 200; i++) begin
      bif.redirect_ready = 1'($urandom_range(0, 3) != 0);
      bif.exaluop_in     = ops[$urandom_range(0, 6)];
      bif.exsrc1_in      = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 : 32'($urandom_range(0, 15));
      bif.exsrc2_in      = 32'($urandom_range(0, 15));
      bif.expc_in        = $urandom;
      bif.exoffset_in    = $urandom;
      bif.ex_branch_en   = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    bif.ex_branch_en   = 1'b0;
    bif.redirect_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    test_reset();
    bif.redirect_ready = 1'b0;
    issue(`BNE, 32'd1, 32'd2, 32'h800, 32'h40);
    @(negedge clk);
    vectors++;
    if (bif.redirect_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_queued: got valid=%b want 1", bif.redirect_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({bif.redirect_valid, bif.redirect_pc, bif.redirect_taken, resolve_en, queue_full,
         overflow_err, branch_cnt, taken_cnt} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: valid=%b pc=%h tk=%b br=%0d tkc=%0d want all 0",
               bif.redirect_valid, bif.redirect_pc, bif.redirect_taken, branch_cnt, taken_cnt);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bif.redirect_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (bif.redirect_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_redirect: got valid=%b want 0", bif.redirect_valid);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst                = 1'b1;
    bif.ex_branch_en   = 1'b0;
    bif.exsrc1_in      = '0;
    bif.exsrc2_in      = '0;
    bif.expc_in        = '0;
    bif.exaluop_in     = '0;
    bif.exoffset_in    = '0;
    bif.redirect_ready = 1'b0;
    #2;
    test_reset();
    test_beq();
    test_signed();
    test_wrap_and_bad_op();
    test_overflow();
    test_full_pushpop();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
